// File: rtl/four_way_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | four_way_rr_arbiter: 4-requester round-robin arbiter with bounded hold,  |
// | one-hot grant via a two_to_four decoder.        Revision: 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module two_to_four (
  input  logic A1,
  input  logic A0,
  input  logic enable,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0
);
  assign Y0 = enable & ~A1 & ~A0;
  assign Y1 = enable & ~A1 &  A0;
  assign Y2 = enable &  A1 & ~A0;
  assign Y3 = enable &  A1 &  A0;
endmodule

module four_way_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic [3:0] gnt,
  output logic       preempt
);
  localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       preempt_q, preempt_d;

  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;

  // Search from last+1; last itself is the final candidate only when idle,
  // since while granted last always equals the current owner.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + k[1:0];
      if (!found && req[cand] && (state_q == ST_IDLE || k != 4)) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          idx_d   = pick;
          last_d  = pick;
          hold_d  = 8'd1;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          if (found) begin
            idx_d  = pick;
            last_d = pick;
            hold_d = 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (hold_q == c_max_hold && found) begin
          idx_d     = pick;
          last_d    = pick;
          hold_d    = 8'd1;
          preempt_d = 1'b1;
        end else if (hold_q != c_max_hold) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      last_q    <= 2'd3;
      hold_q    <= 8'd0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == ST_GRANT);
  assign preempt   = preempt_q;

  two_to_four u_dec (
    .A1     (idx_q[1]),
    .A0     (idx_q[0]),
    .enable (gnt_valid),
    .Y3     (gnt[3]),
    .Y2     (gnt[2]),
    .Y1     (gnt[1]),
    .Y0     (gnt[0])
  );
endmodule

`default_nettype wire

// File: tb/tb_four_way_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_four_way_rr_arbiter: directed self-checking bench, MAX_HOLD = 8.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_four_way_rr_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic [3:0] gnt;
  logic       preempt;

  int checks = 0;
  int fails  = 0;

  four_way_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt       (gnt),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are settled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    tick();
    checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
    checks++; if (gnt_idx !== 2'b00) begin fails++; $display("FAIL reset_idx got=%b exp=00", gnt_idx); end
    checks++; if (preempt !== 1'b0) begin fails++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
    rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    checks++; if (gnt_valid !== 1'b1) begin fails++; $display("FAIL reset_first_valid got=%b exp=1", gnt_valid); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt cyc=%0d got=%b exp=0100", c, gnt); end
      checks++; if (gnt_idx !== 2'b10) begin fails++; $display("FAIL single_idx cyc=%0d got=%b exp=10", c, gnt_idx); end
      checks++; if (preempt !== 1'b0) begin fails++; $display("FAIL single_preempt cyc=%0d got=%b exp=0", c, preempt); end
    end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000) begin fails++; $display("FAIL single_drop_gnt got=%b exp=0000", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL single_drop_valid got=%b exp=0", gnt_valid); end
    checks++; if (gnt_idx !== 2'b10) begin fails++; $display("FAIL single_drop_idx got=%b exp=10", gnt_idx); end
  endtask

  task automatic test_round_robin();
    logic [3:0] req_seq [5];
    logic [3:0] exp_seq [5];
    req_seq = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int s = 0; s < 5; s++) begin
      req = req_seq[s];
      tick();
      checks++; if (gnt !== exp_seq[s]) begin fails++; $display("FAIL rr_gnt step=%0d got=%b exp=%b", s, gnt, exp_seq[s]); end
      checks++; if (gnt_valid !== 1'b1) begin fails++; $display("FAIL rr_valid step=%0d got=%b exp=1", s, gnt_valid); end
    end
  endtask

  task automatic test_forced_rotation();
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (gnt !== 4'b0001 || preempt !== 1'b0) begin fails++; $display("FAIL rot_first gnt cyc=%0d got=%b/%b exp=0001/0", c, gnt, preempt); end
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL rot_second_gnt cyc=%0d got=%b exp=0010", c, gnt); end
      checks++; if (preempt !== (c == 0)) begin fails++; $display("FAIL rot_second_preempt cyc=%0d got=%b exp=%b", c, preempt, (c == 0)); end
    end
    tick();
    checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL rot_back_gnt got=%b exp=0001", gnt); end
    checks++; if (preempt !== 1'b1) begin fails++; $display("FAIL rot_back_preempt got=%b exp=1", preempt); end
  endtask

  task automatic test_boundary_release();
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 8; c++) tick();
    checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL bnd_owner got=%b exp=0001", gnt); end
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL bnd_gnt got=%b exp=0010", gnt); end
    checks++; if (preempt !== 1'b0) begin fails++; $display("FAIL bnd_preempt got=%b exp=0", preempt); end
  endtask

  task automatic test_saturation();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 12; c++) tick();
    req = 4'b0101;
    tick();
    checks++; if (gnt !== 4'b0001) begin fails++; $display("FAIL sat_gnt got=%b exp=0001", gnt); end
    checks++; if (preempt !== 1'b1) begin fails++; $display("FAIL sat_preempt got=%b exp=1", preempt); end
    tick();
    checks++; if (preempt !== 1'b0) begin fails++; $display("FAIL sat_pulse got=%b exp=0", preempt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin fails++; $display("FAIL mrst_pre got=%b exp=0100", gnt); end
    rst_n = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin fails++; $display("FAIL mrst_drop got=%b/%b exp=0000/0", gnt, gnt_valid); end
    rst_n = 1'b1;
    req   = 4'b0110;
    tick();
    checks++; if (gnt !== 4'b0010) begin fails++; $display("FAIL mrst_after got=%b exp=0010", gnt); end
    checks++; if (gnt_idx !== 2'b01) begin fails++; $display("FAIL mrst_idx got=%b exp=01", gnt_idx); end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_forced_rotation();
    test_boundary_release();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/four_way_rr_arbiter.md
# four_way_rr_arbiter

- Round-robin arbiter that shares one resource among four requesters.
- Registers a 2-bit grant index plus a grant-valid flag, which drive the `A1`, `A0` and `enable` inputs of an internal `two_to_four` decoder instance.
- The decoder's `Y3..Y0` outputs form the one-hot grant bus.
- Bounded hold time: an owner that keeps requesting is preempted after `MAX_HOLD` cycles if any other requester is waiting.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before forced rotation when contention exists. Legal range 1..255.
- `clk`  input  1  rising-edge clock; all state updates on this edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on `clk`.
- `req`  input  4  request lines; `req[i]` high means requester i wants the resource. Level-sensitive.
- `gnt_idx`  output  2  registered index of the current owner; `gnt_idx[1]` drives `A1`, `gnt_idx[0]` drives `A0`.
- `gnt_valid`  output  1  registered; high while a grant is active; drives decoder `enable`.
- `gnt`  output  4  one-hot grant from the `two_to_four` instance.
  - `gnt[3]=Y3` … `gnt[0]=Y0`.
  - All zero when `gnt_valid=0`.
- `preempt`  output  1  registered one-cycle pulse, high in the first cycle of a grant produced by forced rotation.

## Operation
- State machine has two states.
  - IDLE: no owner; `gnt_valid=0`.
  - GRANT: owner = `gnt_idx`; `gnt_valid=1`.
- Internal state: `last` (2 bits, index of most recent owner) and `hold_cnt` (8 bits).
- Round-robin search selects the first i with `req[i]=1`, in order (`last`+1, +2, +3, +4) mod 4.
  - In IDLE the search includes `last` itself, as the final candidate.
  - In GRANT the search excludes the current owner.
- IDLE:
  - If `req`≠0, go to GRANT with owner = search result, `hold_cnt`=1, `last`=owner.
  - Otherwise stay in IDLE.
- GRANT, evaluated in priority order:
  - Release: `req[owner]`=0.
    - If another request is pending, switch directly to the search result with no idle bubble; `hold_cnt`=1, `preempt`=0.
    - If none is pending, go to IDLE; `gnt_idx` holds its old value.
  - Forced rotation: `req[owner]`=1, `hold_cnt`=`MAX_HOLD`, and another request is pending. Switch to the search result, `hold_cnt`=1, `preempt`=1 for that one cycle.
  - Continue: `req[owner]`=1 otherwise. `hold_cnt` increments, saturating at `MAX_HOLD`.
- `preempt` is 0 in every cycle not listed above.
- Decoder is purely combinational from the registered `gnt_idx`/`gnt_valid`, so `gnt` is never multi-hot and never glitches relative to `clk`.

## Timing
- Reset (`rst_n`=0 at a rising edge), on that edge:
  - state=IDLE, `gnt_valid`=0, `gnt_idx`=00, `gnt`=0000, `preempt`=0, `hold_cnt`=0.
  - `last`=3, so the first search starts at requester 0.
- Reset mid-grant drops the grant at that same edge; reset overrides all other conditions.
- Latency:
  - Request sampled at edge N appears on `gnt`/`gnt_valid` after edge N, i.e. 1 cycle.
  - Release sampled at edge N: the new owner, or `gnt_valid`=0, is visible after edge N.
- Holding:
  - With contention, an owner holds for exactly `MAX_HOLD` cycles if its request stays high.
  - With no contention, it holds indefinitely.
- Simultaneous requests: resolved purely by the round-robin order from `last`. No requester waits more than 3 grant periods.
- Owner's request falls in the same cycle `hold_cnt` reaches `MAX_HOLD`: treated as a release, so `preempt`=0.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `req`=1111.
  - Expect `gnt`=0000, `gnt_valid`=0, `gnt_idx`=00, `preempt`=0.
  - After `rst_n`=1: `gnt`=0001 one cycle later.
- **Single requester:** `req`=0100 for 20 cycles, then 0000.
  - Expect `gnt`=0100 and `gnt_idx`=10 from cycle 1 through the full 20 cycles, with no preempt.
  - `gnt`=0000 one cycle after the drop.
- **Round robin:** `req`=1111, with each owner dropping its request 1 cycle after being granted, then re-raising it.
  - Expect grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles between grants.
- **Forced rotation** (`MAX_HOLD`=8): `req`=0011 held constant.
  - `gnt`=0001 for 8 cycles, then 0010 for 8 cycles with `preempt`=1 on its first cycle.
  - Then 0001 again.
- **Boundary release:** owner 0 drops its request on exactly its 8th cycle while `req[1]`=1.
  - Expect `gnt`=0010 with `preempt`=0.
- **Mid-operation reset:** assert `rst_n`=0 during grant to requester 2.
  - Expect `gnt`=0000 at the next edge.
  - After release with `req`=0110, expect first `gnt`=0010.
